morse_letter_decoder: RTL and testbench
=======================================

Name: morse_letter_decoder

Overview:
- Upstream stage of the seven-segment letter decoder.
- Samples the Morse key, times each press and gap using a tick enable, and classifies each press as a dot or a dash.
- Accumulates up to 4 symbols per letter. After a letter gap it looks the pattern up and presents the letter index 0..25 (A..Z) on oLetter, which drives the decoder's iData directly.
- Patterns that are not letters are flagged on oError.

Parameters:
- CNT_W, 12, width of the tick counter; saturates at 2^CNT_W-1.
- MIN_PRESS_TICKS, 10, presses shorter than this are glitches and are discarded.
- DASH_TICKS, 200, a press of at least this many ticks is a dash; shorter is a dot.
- LETTER_GAP_TICKS, 400, key-low ticks that end a letter.

Ports:
- iClk  in  1  system clock.
- iRst_n  in  1  asynchronous active-low reset.
- iTick  in  1  single-cycle timing enable (e.g. 1 ms strobe); all counting happens only on iTick=1.
- iKey  in  1  Morse key, active high, asynchronous to iClk.
- oLetter  out  5  last successfully decoded letter, 0=A..25=Z; 31 = blank.
- oValid  out  1  one-cycle pulse when oLetter is updated.
- oError  out  1  one-cycle pulse when a pattern is invalid or overflows.
- oSymCnt  out  3  symbols accumulated in the current letter, 0..4.
- oBusy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: clock and reset are a single clock and an asynchronous active-low reset (iClk, iRst_n). Reset clears all state:
  - oLetter=5'd31, oValid=0, oError=0, oSymCnt=0, oBusy=0.
  - FSM to IDLE; counter, pattern register, overflow flag and synchroniser cleared.
  - Reset may be asserted in any state, mid-press or mid-gap. Any partial letter is lost, and no oValid or oError is produced.
- Input synchroniser: iKey passes through a 2-flop synchroniser to give key_s. The FSM reacts to key_s only, so there is 2 cycles of latency from the iKey edge.
- Pattern register: 4 bits, dash=1, dot=0. Each new symbol is shifted in at the LSB. It is qualified by a length count of 0..4.
- FSM, IDLE:
  - key_s=1: go to PRESS and set cnt=0.
- FSM, PRESS:
  - On each iTick, cnt increments, saturating.
  - key_s=0: classify using cnt. An iTick arriving in the same cycle is not counted.
    - cnt<MIN_PRESS_TICKS: discard the press. Go to GAP if len>0, else IDLE.
    - Otherwise: dash if cnt>=DASH_TICKS, else dot.
    - If len<4, append the symbol and increment len. If len=4, set the overflow flag and leave len at 4.
    - Go to GAP with cnt=0.
- FSM, GAP:
  - On each iTick, cnt increments.
  - When cnt reaches LETTER_GAP_TICKS, go to EMIT. This has priority over key_s=1 in the same cycle.
  - Otherwise key_s=1 goes to PRESS with cnt=0.
- FSM, EMIT (exactly 1 cycle):
  - Combinational lookup of (len, pattern) against the standard international Morse letters A..Z.
  - Hit with no overflow: register the index into oLetter and pulse oValid. The index and the pulse appear together on the cycle after EMIT.
  - Miss, overflow, or len=0: pulse oError and leave oLetter unchanged.
  - Clear len, pattern, overflow flag and cnt, then go to IDLE.
  - If the key is already held, IDLE re-enters PRESS on the next cycle.
- Outputs:
  - oValid and oError are never high together, and are never high for more than 1 cycle.
  - oSymCnt = len.
  - oBusy = (state != IDLE).
- Counter saturates at 2^CNT_W-1 and never wraps. A very long press is a dash.
- iTick is ignored in IDLE and EMIT.

Test Plan:
- Dot then dash: press 50 ticks, release 100 ticks, press 300 ticks, release 400 ticks -> oValid pulses once, oLetter=0 (A), oSymCnt reads 1 then 2 then 0 after EMIT.
- Dot/dash threshold: press exactly 199 ticks then gap 400 -> oLetter=4 (E). Press exactly 200 ticks then gap 400 -> oLetter=19 (T).
- Full four-symbol letter: dash, dot, dot, dot with 100-tick intra-gaps -> oLetter=1 (B). Dash, dash, dot, dash -> oLetter=16 (Q).
- Errors and glitches:
  - Five dots -> oError pulse, no oValid, oLetter keeps its previous value.
  - Four dashes -> oError pulse.
  - A single 5-tick press followed by 500 idle ticks -> no pulses, and the FSM returns to IDLE.
- Gap boundary: gap of 399 ticks between dot and dash -> single letter A. Gap of 400 ticks -> E (oLetter=4) emitted, then T (oLetter=19) on the next gap.
- Reset mid-operation: assert iRst_n=0 during PRESS after 2 symbols -> all outputs return immediately to oLetter=31, oValid=0, oError=0, oSymCnt=0, oBusy=0. After release there is no spurious pulse.

Source files
------------

// File: rtl/morse_letter_decoder.sv
// Morse key front end: times presses and gaps on iTick, classifies dots and dashes,
// and looks the accumulated pattern up as a letter index 0..25 (A..Z).
module morse_letter_decoder #(
   parameter int CNT_W            = 12,
   parameter int MIN_PRESS_TICKS  = 10,
   parameter int DASH_TICKS       = 200,
   parameter int LETTER_GAP_TICKS = 400
) (
   input  logic       iClk,
   input  logic       iRst_n,
   input  logic       iTick,
   input  logic       iKey,
   output logic [4:0] oLetter,
   output logic       oValid,
   output logic       oError,
   output logic [2:0] oSymCnt,
   output logic       oBusy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PRESS = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;
   localparam logic [1:0] ST_EMIT  = 2'd3;

   localparam logic [CNT_W-1:0] min_press = CNT_W'(MIN_PRESS_TICKS);
   localparam logic [CNT_W-1:0] dash_min  = CNT_W'(DASH_TICKS);
   localparam logic [CNT_W-1:0] gap_end   = CNT_W'(LETTER_GAP_TICKS);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [3:0]       pat;
   logic [2:0]       len;
   logic             ovf;
   logic             key_m;
   logic             key_s;
   logic             hit;
   logic [4:0]       idx;

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         key_m <= 1'b0;
         key_s <= 1'b0;
      end else begin
         key_m <= iKey;
         key_s <= key_m;
      end
   end

   assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

   // Symbols enter at the LSB, so the first symbol sits at bit len-1.
   always_comb begin
      hit = 1'b1;
      idx = '0;
      case ({len, pat})
         {3'd2, 4'b0001}: idx = 5'd0;
         {3'd4, 4'b1000}: idx = 5'd1;
         {3'd4, 4'b1010}: idx = 5'd2;
         {3'd3, 4'b0100}: idx = 5'd3;
         {3'd1, 4'b0000}: idx = 5'd4;
         {3'd4, 4'b0010}: idx = 5'd5;
         {3'd3, 4'b0110}: idx = 5'd6;
         {3'd4, 4'b0000}: idx = 5'd7;
         {3'd2, 4'b0000}: idx = 5'd8;
         {3'd4, 4'b0111}: idx = 5'd9;
         {3'd3, 4'b0101}: idx = 5'd10;
         {3'd4, 4'b0100}: idx = 5'd11;
         {3'd2, 4'b0011}: idx = 5'd12;
         {3'd2, 4'b0010}: idx = 5'd13;
         {3'd3, 4'b0111}: idx = 5'd14;
         {3'd4, 4'b0110}: idx = 5'd15;
         {3'd4, 4'b1101}: idx = 5'd16;
         {3'd3, 4'b0010}: idx = 5'd17;
         {3'd3, 4'b0000}: idx = 5'd18;
         {3'd1, 4'b0001}: idx = 5'd19;
         {3'd3, 4'b0001}: idx = 5'd20;
         {3'd4, 4'b0001}: idx = 5'd21;
         {3'd3, 4'b0011}: idx = 5'd22;
         {3'd4, 4'b1001}: idx = 5'd23;
         {3'd4, 4'b1011}: idx = 5'd24;
         {3'd4, 4'b1100}: idx = 5'd25;
         default:         hit = 1'b0;
      endcase
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         pat     <= '0;
         len     <= '0;
         ovf     <= 1'b0;
         oLetter <= 5'd31;
         oValid  <= 1'b0;
         oError  <= 1'b0;
      end else begin
         oValid <= 1'b0;
         oError <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (key_s) begin
                  state <= ST_PRESS;
                  cnt   <= '0;
               end
            end
            ST_PRESS: begin
               if (!key_s) begin
                  cnt <= '0;
                  if (cnt < min_press) begin
                     state <= (len != 3'd0) ? ST_GAP : ST_IDLE;
                  end else begin
                     state <= ST_GAP;
                     if (len != 3'd4) begin
                        pat <= {pat[2:0], (cnt >= dash_min)};
                        len <= len + 3'd1;
                     end else begin
                        ovf <= 1'b1;
                     end
                  end
               end else if (iTick) begin
                  cnt <= cnt_inc;
               end
            end
            ST_GAP: begin
               if (cnt >= gap_end) begin
                  state <= ST_EMIT;
               end else if (key_s) begin
                  state <= ST_PRESS;
                  cnt   <= '0;
               end else if (iTick) begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               if (hit && !ovf) begin
                  oLetter <= idx;
                  oValid  <= 1'b1;
               end else begin
                  oError <= 1'b1;
               end
               len   <= '0;
               pat   <= '0;
               ovf   <= 1'b0;
               cnt   <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign oSymCnt = len;
   assign oBusy   = (state != ST_IDLE);

endmodule

// File: tb/tb_morse_letter_decoder.sv
// Directed bench for morse_letter_decoder: keys letters with explicit tick counts
// and checks letter, pulse and status outputs against hand-derived values.
module tb_morse_letter_decoder;

   logic       iClk;
   logic       iRst_n;
   logic       iTick;
   logic       iKey;
   logic [4:0] oLetter;
   logic       oValid;
   logic       oError;
   logic [2:0] oSymCnt;
   logic       oBusy;

   int total  = 0;
   int passed = 0;
   int vcnt   = 0;
   int ecnt   = 0;
   int both   = 0;
   int longp  = 0;
   logic [4:0] last_letter = 5'd31;
   logic prev_v = 1'b0;
   logic prev_e = 1'b0;

   morse_letter_decoder #(
      .CNT_W(12),
      .MIN_PRESS_TICKS(10),
      .DASH_TICKS(200),
      .LETTER_GAP_TICKS(400)
   ) dut (
      .iClk(iClk),
      .iRst_n(iRst_n),
      .iTick(iTick),
      .iKey(iKey),
      .oLetter(oLetter),
      .oValid(oValid),
      .oError(oError),
      .oSymCnt(oSymCnt),
      .oBusy(oBusy)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   // Pulse monitor, sampled just after each rising edge.
   always @(posedge iClk) begin
      #1;
      if (iRst_n) begin
         if (oValid) begin
            vcnt++;
            last_letter = oLetter;
         end
         if (oError) ecnt++;
         if (oValid && oError) both++;
         if ((oValid && prev_v) || (oError && prev_e)) longp++;
      end
      prev_v = oValid;
      prev_e = oError;
   end

   task automatic cycles(input int n, input logic tick);
      for (int i = 0; i < n; i++) begin
         iTick = tick;
         @(negedge iClk);
      end
      iTick = 1'b0;
   endtask

   // Three idle cycles cover the synchroniser and the state change on each key edge.
   task automatic press(input int n);
      iKey = 1'b1;
      cycles(3, 1'b0);
      cycles(n, 1'b1);
      iKey = 1'b0;
      cycles(3, 1'b0);
   endtask

   task automatic end_letter();
      cycles(400, 1'b1);
      cycles(4, 1'b0);
   endtask

   task automatic test_reset();
      iRst_n = 1'b0;
      iKey   = 1'b0;
      iTick  = 1'b0;
      cycles(4, 1'b0);
      iRst_n = 1'b1;
      cycles(2, 1'b0);
      total++;
      if (oLetter !== 5'd31 || oValid !== 1'b0 || oError !== 1'b0 || oSymCnt !== 3'd0 || oBusy !== 1'b0)
         $display("FAIL reset_state: got letter=%0d v=%b e=%b sym=%0d busy=%b, want 31 0 0 0 0",
                  oLetter, oValid, oError, oSymCnt, oBusy);
      else passed++;
   endtask

   task automatic test_dot_dash();
      int v0 = vcnt;
      press(50);
      total++;
      if (oSymCnt !== 3'd1) $display("FAIL a_symcnt1: got %0d want 1", oSymCnt); else passed++;
      cycles(100, 1'b1);
      press(300);
      total++;
      if (oSymCnt !== 3'd2) $display("FAIL a_symcnt2: got %0d want 2", oSymCnt); else passed++;
      total++;
      if (oBusy !== 1'b1) $display("FAIL a_busy: got %b want 1", oBusy); else passed++;
      end_letter();
      total++;
      if (vcnt - v0 != 1 || oLetter !== 5'd0)
         $display("FAIL a_letter: got %0d pulses letter=%0d, want 1 pulse letter=0", vcnt - v0, oLetter);
      else passed++;
      total++;
      if (oSymCnt !== 3'd0 || oBusy !== 1'b0)
         $display("FAIL a_after_emit: got sym=%0d busy=%b want 0 0", oSymCnt, oBusy);
      else passed++;
   endtask

   task automatic test_threshold();
      int v0 = vcnt;
      press(199);
      end_letter();
      total++;
      if (vcnt - v0 != 1 || last_letter !== 5'd4)
         $display("FAIL dot_199: got %0d pulses letter=%0d, want 1 letter=4", vcnt - v0, last_letter);
      else passed++;
      press(200);
      end_letter();
      total++;
      if (vcnt - v0 != 2 || last_letter !== 5'd19)
         $display("FAIL dash_200: got %0d pulses letter=%0d, want 2 letter=19", vcnt - v0, last_letter);
      else passed++;
   endtask

   task automatic test_four_symbol();
      int v0 = vcnt;
      press(300); cycles(100, 1'b1);
      press(50);  cycles(100, 1'b1);
      press(50);  cycles(100, 1'b1);
      press(50);
      total++;
      if (oSymCnt !== 3'd4) $display("FAIL b_symcnt4: got %0d want 4", oSymCnt); else passed++;
      end_letter();
      total++;
      if (vcnt - v0 != 1 || last_letter !== 5'd1)
         $display("FAIL letter_b: got %0d pulses letter=%0d, want 1 letter=1", vcnt - v0, last_letter);
      else passed++;
      press(300); cycles(100, 1'b1);
      press(300); cycles(100, 1'b1);
      press(50);  cycles(100, 1'b1);
      press(300);
      end_letter();
      total++;
      if (vcnt - v0 != 2 || oLetter !== 5'd16)
         $display("FAIL letter_q: got %0d pulses letter=%0d, want 2 letter=16", vcnt - v0, oLetter);
      else passed++;
   endtask

   task automatic test_errors();
      int v0 = vcnt;
      int e0 = ecnt;
      for (int i = 0; i < 5; i++) begin
         press(50);
         if (i < 4) cycles(100, 1'b1);
      end
      total++;
      if (oSymCnt !== 3'd4) $display("FAIL ovf_symcnt: got %0d want 4", oSymCnt); else passed++;
      end_letter();
      total++;
      if (ecnt - e0 != 1 || vcnt != v0 || oLetter !== 5'd16)
         $display("FAIL five_dots: got err=%0d val=%0d letter=%0d, want 1 0 16", ecnt - e0, vcnt - v0, oLetter);
      else passed++;
      for (int i = 0; i < 4; i++) begin
         press(300);
         if (i < 3) cycles(100, 1'b1);
      end
      end_letter();
      total++;
      if (ecnt - e0 != 2 || vcnt != v0 || oLetter !== 5'd16)
         $display("FAIL four_dashes: got err=%0d val=%0d letter=%0d, want 2 0 16", ecnt - e0, vcnt - v0, oLetter);
      else passed++;
      press(5);
      cycles(500, 1'b1);
      total++;
      if (ecnt - e0 != 2 || vcnt != v0 || oBusy !== 1'b0 || oSymCnt !== 3'd0)
         $display("FAIL glitch: got err=%0d val=%0d busy=%b sym=%0d, want 2 0 0 0",
                  ecnt - e0, vcnt - v0, oBusy, oSymCnt);
      else passed++;
   endtask

   task automatic test_gap_boundary();
      int v0 = vcnt;
      press(50);
      cycles(399, 1'b1);
      press(300);
      end_letter();
      total++;
      if (vcnt - v0 != 1 || last_letter !== 5'd0)
         $display("FAIL gap_399: got %0d pulses letter=%0d, want 1 letter=0", vcnt - v0, last_letter);
      else passed++;
      press(50);
      cycles(400, 1'b1);
      cycles(4, 1'b0);
      total++;
      if (vcnt - v0 != 2 || last_letter !== 5'd4)
         $display("FAIL gap_400_e: got %0d pulses letter=%0d, want 2 letter=4", vcnt - v0, last_letter);
      else passed++;
      press(300);
      end_letter();
      total++;
      if (vcnt - v0 != 3 || last_letter !== 5'd19)
         $display("FAIL gap_400_t: got %0d pulses letter=%0d, want 3 letter=19", vcnt - v0, last_letter);
      else passed++;
   endtask

   task automatic test_reset_mid();
      int v0 = vcnt;
      int e0 = ecnt;
      press(50);  cycles(100, 1'b1);
      press(300); cycles(100, 1'b1);
      iKey = 1'b1;
      cycles(3, 1'b0);
      cycles(20, 1'b1);
      total++;
      if (oSymCnt !== 3'd2 || oBusy !== 1'b1)
         $display("FAIL pre_reset: got sym=%0d busy=%b want 2 1", oSymCnt, oBusy);
      else passed++;
      iRst_n = 1'b0;
      #1;
      total++;
      if (oLetter !== 5'd31 || oValid !== 1'b0 || oError !== 1'b0 || oSymCnt !== 3'd0 || oBusy !== 1'b0)
         $display("FAIL reset_mid: got letter=%0d v=%b e=%b sym=%0d busy=%b, want 31 0 0 0 0",
                  oLetter, oValid, oError, oSymCnt, oBusy);
      else passed++;
      @(negedge iClk);
      iKey = 1'b0;
      cycles(3, 1'b0);
      iRst_n = 1'b1;
      cycles(500, 1'b1);
      total++;
      if (vcnt != v0 || ecnt != e0 || oLetter !== 5'd31 || oBusy !== 1'b0)
         $display("FAIL post_reset: got val=%0d err=%0d letter=%0d busy=%b, want 0 0 31 0",
                  vcnt - v0, ecnt - e0, oLetter, oBusy);
      else passed++;
   endtask

   task automatic test_pulse_rules();
      total++;
      if (both != 0 || longp != 0)
         $display("FAIL pulse_rules: got overlap=%0d long=%0d want 0 0", both, longp);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_dot_dash();
      test_threshold();
      test_four_symbol();
      test_errors();
      test_gap_boundary();
      test_reset_mid();
      test_pulse_rules();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
